ser_tx8: RTL and testbench
==========================

Name: ser_tx8

Overview:
- Byte serializer: accepts an 8-bit word through a valid/ready handshake and shifts it out on a single line as an asynchronous-serial frame.
- Frame format: start bit 0, eight data bits LSB first, stop bit 1.
- Sits directly downstream of the 8-bit pipeline register; that register's q drives d here.
- Bit period is a fixed number of clk cycles set by parameter.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal range 1..65535. Counter width is $clog2(CLKS_PER_BIT), minimum 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- d  input  8  byte to transmit; sampled only on an accepting edge.
- valid  input  1  upstream has a byte on d.
- ready  output  1  block can accept a byte; registered.
- txd  output  1  serial line; registered; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately at any time):
  - State to IDLE.
  - txd=1, ready=1, busy=0, done=0.
  - Shift register and counters cleared.
- Release of rst takes effect at the next rising edge.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - ready=1, txd=1, busy=0.
  - Accept on a rising edge T0 where valid=1 and ready=1.
  - At T0: shreg<=d, state<=START, txd<=0, ready<=0, busy<=1, bit counter<=0, cycle counter<=0.
- START: txd=0 from edge T0 to edge T0+N, where N=CLKS_PER_BIT.
- DATA:
  - Bit i (i=0..7) drives txd=shreg[i] from edge T0+N*(1+i) to edge T0+N*(2+i).
  - Shift right, or index by the 3-bit bit counter.
- STOP: txd=1 from edge T0+9N to edge T0+10N.
- At edge T0+10N:
  - State<=IDLE, ready<=1, busy<=0.
  - done<=1 for exactly one cycle; it clears on the next edge.
- Every bit lasts exactly N cycles, including N=1. The cycle counter counts 0..N-1 and wraps.
- Frame length from accepting edge to ready re-asserted is 10N cycles.
- Back-to-back:
  - Accept is allowed only when ready=1 is registered, so at least one IDLE cycle (txd=1) separates frames.
  - Minimum frame pitch is 10N+1 cycles.
  - If valid is held high, the next byte is accepted on edge T0+10N+1.
- valid while ready=0: ignored; no queueing. Upstream holds d/valid until it sees ready.
- Changes on d after the accepting edge do not affect the frame in flight.
- No combinational path from valid or d to any output.
- Reset mid-frame:
  - txd returns to 1 immediately (asynchronously).
  - The partial frame is abandoned and done is not pulsed.
  - After release, the first accept starts a fresh full frame.

Test Plan:
- Reset values: assert rst=0 mid-simulation with no clock edge -> txd=1, ready=1, busy=0, done=0 immediately. Release, idle 5 cycles with valid=0 -> outputs unchanged.
- Single frame, N=4, d=8'hA5 with valid for one accepting cycle:
  - txd per 4-cycle bit = 0, 1,0,1,0,0,1,0,1, 1.
  - ready low for 40 cycles; done high only in cycle 41.
  - Bench reconstructs 8'hA5.
- Back-to-back, N=4: 8'h00 then 8'hFF, valid held high -> second accept exactly 41 cycles after first, one idle-high cycle between frames, both bytes recovered.
- Input stability: accept d=8'h3C, then drive d=8'hFF and toggle valid during the frame -> frame carries 8'h3C; no extra frame starts.
- Reset mid-frame: assert rst=0 during data bit 3 of 8'h81 -> txd=1 at once, no done pulse. After release, send 8'h7E -> full correct frame.
- N=1 corner: CLKS_PER_BIT=1, d=8'h96 -> 10-cycle frame 0,0,1,1,0,1,0,0,1,1; ready returns after 10 cycles.

Source files
------------

// File: rtl/ser_tx8.sv
// Byte serializer: 8N1-style frame (start 0, 8 data LSB first, stop 1), CLKS_PER_BIT clocks per bit.
// Accept-to-ready is 10*CLKS_PER_BIT cycles; ready is low for the whole frame, and valid is ignored while low.
module ser_tx8 #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit;
    logic [CW-1:0] r_cnt;
    logic          r_txd;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;

    logic w_accept;
    logic w_bit_end;

    assign w_accept  = valid & r_ready;
    assign w_bit_end = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_txd   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg <= d;
                        r_state <= START;
                        r_txd   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_txd   <= r_shreg[0];
                        r_bit   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            // shreg[0] is always the bit currently on the line
                            r_bit   <= r_bit + 3'd1;
                            r_shreg <= {1'b0, r_shreg[7:1]};
                            r_txd   <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = r_ready;
    assign txd   = r_txd;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

// File: tb/tb_ser_tx8.sv
// Bench for ser_tx8 at CLKS_PER_BIT=4 and CLKS_PER_BIT=1 against a frame-level reference model.
module tb_ser_tx8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d4, d1;
    logic       valid4, valid1;
    logic       ready4, txd4, busy4, done4;
    logic       ready1, txd1, busy1, done1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ser_tx8 #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .d(d4), .valid(valid4),
        .ready(ready4), .txd(txd4), .busy(busy4), .done(done4)
    );

    ser_tx8 #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .valid(valid1),
        .ready(ready1), .txd(txd1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level k cycles after the accepting edge: frame is {stop, data, start} sent LSB first.
    function automatic logic model_bit(input logic [7:0] b, input int n, input int k);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        return fr[k / n];
    endfunction

    function automatic logic [3:0] outs(input int which);
        if (which == 1) return {ready1, txd1, busy1, done1};
        return {ready4, txd4, busy4, done4};
    endfunction

    task automatic drive(input int which, input logic [7:0] dv, input logic vv);
        if (which == 1) begin
            d1 = dv; valid1 = vv;
        end else begin
            d4 = dv; valid4 = vv;
        end
    endtask

    // Called at a negedge; presents b, lets it be accepted, checks every cycle of the frame.
    // Returns at the negedge after the stop bit ends (ready re-asserted, done high).
    task automatic frame(input int which, input int n, input logic [7:0] b, input bit hold,
                         input logic [7:0] nb, input bit disturb, input int prev_acc, output int acc);
        logic [7:0] rec;
        logic [3:0] o;
        rec = 8'h00;
        drive(which, b, 1'b1);
        o = outs(which);
        chk("ready_before_accept", 32'(o[3]), 32'd1);
        acc = cyc;
        if (prev_acc >= 0) chk("accept_pitch", 32'(acc - prev_acc), 32'(10 * n + 1));
        @(negedge clk);
        if (hold) drive(which, nb, 1'b1);
        else drive(which, ~b, 1'b0);
        for (int k = 0; k < 10 * n; k++) begin
            if (disturb) drive(which, 8'hFF, (k == 10 * n - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
            o = outs(which);
            chk("txd_bit", 32'(o[2]), 32'(model_bit(b, n, k)));
            chk("ready_low", 32'(o[3]), 32'd0);
            chk("busy_high", 32'(o[1]), 32'd1);
            chk("done_low", 32'(o[0]), 32'd0);
            if ((k % n) == (n / 2) && (k / n) >= 1 && (k / n) <= 8) rec[k / n - 1] = o[2];
            @(negedge clk);
        end
        o = outs(which);
        chk("ready_end", 32'(o[3]), 32'd1);
        chk("busy_end", 32'(o[1]), 32'd0);
        chk("done_pulse", 32'(o[0]), 32'd1);
        chk("txd_idle_gap", 32'(o[2]), 32'd1);
        chk("byte_recovered", 32'(rec), 32'(b));
        if (!hold) begin
            @(negedge clk);
            o = outs(which);
            chk("done_clears", 32'(o[0]), 32'd0);
            chk("ready_stays", 32'(o[3]), 32'd1);
        end
    endtask

    task automatic idle_check(input int which, input int cycles, input string tag);
        logic [3:0] o;
        for (int i = 0; i < cycles; i++) begin
            o = outs(which);
            chk(tag, 32'(o), 32'b1100);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a, acc_b, dummy;
        logic [7:0] rb;
        logic [3:0] o;
        rst = 1'b0;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1 chk("reset_async_outs", 32'(outs(0)), 32'b1100);
        @(negedge clk);
        rst = 1'b1;
        idle_check(0, 5, "idle_after_reset");
        idle_check(1, 1, "idle_n1");

        frame(0, 4, 8'hA5, 1'b0, 8'h00, 1'b0, -1, dummy);

        // Back-to-back with valid held high
        frame(0, 4, 8'h00, 1'b1, 8'hFF, 1'b0, -1, acc_a);
        frame(0, 4, 8'hFF, 1'b0, 8'h00, 1'b0, acc_a, acc_b);

        // d and valid disturbed during the frame
        frame(0, 4, 8'h3C, 1'b0, 8'h00, 1'b1, -1, dummy);
        idle_check(0, 12, "no_extra_frame");

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rb = 8'($urandom);
            frame(0, 4, rb, 1'b0, 8'h00, 1'b0, -1, dummy);
        end

        // Reset during data bit 3 of 8'h81
        drive(0, 8'h81, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0);
        repeat (18) @(negedge clk);
        chk("pre_reset_bit3", 32'(txd4), 32'(model_bit(8'h81, 4, 18)));
        #2 rst = 1'b0;
        #1 o = outs(0);
        chk("midframe_reset_outs", 32'(o), 32'b1100);
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_done", 32'(done4), 32'd0);
        end
        rst = 1'b1;
        idle_check(0, 4, "idle_after_midreset");
        frame(0, 4, 8'h7E, 1'b0, 8'h00, 1'b0, -1, dummy);

        // One clock per bit
        frame(1, 1, 8'h96, 1'b0, 8'h00, 1'b0, -1, dummy);
        frame(1, 1, 8'h5A, 1'b1, 8'hC3, 1'b0, -1, acc_a);
        frame(1, 1, 8'hC3, 1'b0, 8'h00, 1'b0, acc_a, acc_b);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rb = 8'($urandom);
            frame(1, 1, rb, 1'b0, 8'h00, 1'b0, -1, dummy);
        end
        idle_check(1, 3, "idle_n1_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
